// File: rtl/sd_pkg.sv
// Shared constants, state types and the CRC7 bit step for the SD SPI command/response unit.
package sd_pkg;
  localparam int         FRAME_LEN    = 48;
  localparam int         CRC_LEN      = 40;
  localparam logic [6:0] CRC7_POLY    = 7'h09;
  localparam int         R1_LEN       = 8;
  localparam int         R7_LEN       = 40;
  localparam logic [3:0] TOK_ACCEPTED = 4'b0101;
  localparam logic [3:0] TOK_CRC_ERR  = 4'b1011;
  localparam logic [3:0] TOK_WR_ERR   = 4'b1101;

  typedef enum logic [2:0] {C_IDLE, C_SEND, C_WAIT, C_CAPT, C_DONE} cmd_state_e;
  typedef enum logic [2:0] {D_IDLE, D_ARMED, D_TOKEN, D_BUSY, D_DONE} dat_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), one message bit per enabled clock, MSB first.
module sd_crc7 import sd_pkg::*; (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);
  logic [6:0] r_crc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_crc <= '0;
    else if (i_clear) r_crc <= '0;
    else if (i_en)    r_crc <= crc7_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/sd_cmd_resp_unit.sv
// SD SPI-mode command sender / response capture, data-response token tracker and delay counter.
module sd_cmd_resp_unit import sd_pkg::*; #(
  parameter int NCR_MAX = 64,
  parameter int DLY_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_do,
  input  logic             i_cmd_start,
  input  logic [5:0]       i_cmd_index,
  input  logic [31:0]      i_cmd_arg,
  input  logic             i_cmd_long,
  output logic             o_cmd_di,
  output logic             o_cmd_busy,
  output logic             o_cmd_finish,
  output logic             o_cmd_rp_finish,
  output logic [39:0]      o_cmd_response,
  input  logic             i_dat_clear,
  output logic             o_dat_finish,
  output logic [3:0]       o_dat_status,
  input  logic             i_dly_start,
  input  logic [DLY_W-1:0] i_dly_times,
  output logic             o_dly_finish
);
  localparam int NCR_W = $clog2(NCR_MAX + 1);

  cmd_state_e       r_cst;
  logic [38:0]      r_tx;
  logic [5:0]       r_bit;
  logic [NCR_W-1:0] r_ncr;
  logic [39:0]      r_rx;
  logic             r_long;
  logic             r_start_ok;
  logic             r_cmd_di;
  logic             r_busy;
  logic             r_finish;
  logic             r_rp_finish;
  logic [39:0]      r_resp;

  logic [6:0]       w_crc;
  logic             w_crc_clr;
  logic             w_crc_en;
  logic [39:0]      w_rx_next;
  logic [5:0]       w_rx_last;

  // Frame bit 0 is always 0 and the CRC starts at 0, so feeding only bits 1..39 gives the same remainder.
  assign w_crc_clr = (r_cst == C_IDLE);
  assign w_crc_en  = (r_cst == C_SEND) && (r_bit < 6'(CRC_LEN - 1));
  assign w_rx_next = {r_rx[38:0], i_do};
  assign w_rx_last = r_long ? 6'(R7_LEN - 1) : 6'(R1_LEN - 1);

  sd_crc7 u_crc7 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_crc_clr),
    .i_en    (w_crc_en),
    .i_bit   (r_tx[38]),
    .o_crc   (w_crc)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cst       <= C_IDLE;
      r_tx        <= '0;
      r_bit       <= '0;
      r_ncr       <= '0;
      r_rx        <= '0;
      r_long      <= 1'b0;
      r_start_ok  <= 1'b0;
      r_cmd_di    <= 1'b1;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_rp_finish <= 1'b0;
      r_resp      <= '0;
    end else begin
      r_rp_finish <= 1'b0;
      // A command only launches after cmd_start has been seen low (after reset or a finished command).
      if (!i_cmd_start) r_start_ok <= 1'b1;
      case (r_cst)
        C_IDLE: begin
          r_cmd_di <= 1'b1;
          r_busy   <= 1'b0;
          if (i_cmd_start && r_start_ok) begin
            r_start_ok <= 1'b0;
            r_long     <= i_cmd_long;
            r_tx       <= {1'b1, i_cmd_index, i_cmd_arg};
            r_cmd_di   <= 1'b0;
            r_busy     <= 1'b1;
            r_bit      <= '0;
            r_cst      <= C_SEND;
          end
        end
        C_SEND: begin
          r_bit <= r_bit + 6'd1;
          if (r_bit == 6'(CRC_LEN - 1)) begin
            r_cmd_di <= w_crc[6];
            r_tx     <= {w_crc[5:0], 1'b1, 32'd0};
          end else if (r_bit == 6'(FRAME_LEN - 1)) begin
            r_cmd_di <= 1'b1;
            r_ncr    <= '0;
            r_cst    <= C_WAIT;
          end else begin
            r_cmd_di <= r_tx[38];
            r_tx     <= {r_tx[37:0], 1'b0};
          end
        end
        C_WAIT: begin
          if (!i_do) begin
            r_rx  <= '0;
            r_bit <= 6'd1;
            r_cst <= C_CAPT;
          end else if (r_ncr == NCR_W'(NCR_MAX - 1)) begin
            r_resp      <= '1;
            r_rp_finish <= 1'b1;
            r_finish    <= 1'b1;
            r_cst       <= C_DONE;
          end else begin
            r_ncr <= r_ncr + 1'b1;
          end
        end
        C_CAPT: begin
          r_rx  <= w_rx_next;
          r_bit <= r_bit + 6'd1;
          if (r_bit == w_rx_last) begin
            r_resp      <= r_long ? w_rx_next : {32'd0, w_rx_next[7:0]};
            r_rp_finish <= 1'b1;
            r_finish    <= 1'b1;
            r_cst       <= C_DONE;
          end
        end
        C_DONE: begin
          if (!i_cmd_start) begin
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_cst    <= C_IDLE;
          end
        end
        default: r_cst <= C_IDLE;
      endcase
    end
  end

  assign o_cmd_di        = r_cmd_di;
  assign o_cmd_busy      = r_busy;
  assign o_cmd_finish    = r_finish;
  assign o_cmd_rp_finish = r_rp_finish;
  assign o_cmd_response  = r_resp;

  dat_state_e r_dst;
  logic [1:0] r_tok_cnt;
  logic [3:0] r_status;
  logic       r_dat_finish;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dst        <= D_IDLE;
      r_tok_cnt    <= '0;
      r_status     <= '0;
      r_dat_finish <= 1'b0;
    end else if (i_dat_clear) begin
      r_dst        <= D_IDLE;
      r_tok_cnt    <= '0;
      r_status     <= '0;
      r_dat_finish <= 1'b0;
    end else begin
      case (r_dst)
        D_IDLE:  if (r_rp_finish) r_dst <= D_ARMED;
        D_ARMED: begin
          if (!i_do) begin
            r_tok_cnt <= '0;
            r_dst     <= D_TOKEN;
          end
        end
        D_TOKEN: begin
          r_status  <= {r_status[2:0], i_do};
          r_tok_cnt <= r_tok_cnt + 2'd1;
          if (r_tok_cnt == 2'd3) r_dst <= D_BUSY;
        end
        D_BUSY: begin
          if (i_do) begin
            r_dat_finish <= 1'b1;
            r_dst        <= D_DONE;
          end
        end
        D_DONE:  r_dat_finish <= 1'b1;
        default: r_dst <= D_IDLE;
      endcase
    end
  end

  assign o_dat_finish = r_dat_finish;
  assign o_dat_status = r_status;

  logic [DLY_W-1:0] r_dly_cnt;
  logic             r_dly_finish;

  // Saturating edge counter; finish is sticky until dly_start drops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dly_cnt    <= '0;
      r_dly_finish <= 1'b0;
    end else if (!i_dly_start) begin
      r_dly_cnt    <= '0;
      r_dly_finish <= 1'b0;
    end else begin
      r_dly_finish <= r_dly_finish | (r_dly_cnt >= i_dly_times);
      if (r_dly_cnt != '1) r_dly_cnt <= r_dly_cnt + 1'b1;
    end
  end

  assign o_dly_finish = r_dly_finish;
endmodule

// File: tb/tb_sd_cmd_resp_unit.sv
// Randomized bench for sd_cmd_resp_unit against a bit-stream reference model of the SPI exchange.
module tb_sd_cmd_resp_unit;
  import sd_pkg::*;

  localparam int NCR = 64;

  logic        clk;
  logic        i_reset, i_do, i_cmd_start, i_cmd_long, i_dat_clear, i_dly_start;
  logic [5:0]  i_cmd_index;
  logic [31:0] i_cmd_arg;
  logic [3:0]  i_dly_times;
  logic        o_cmd_di, o_cmd_busy, o_cmd_finish, o_cmd_rp_finish, o_dat_finish, o_dly_finish;
  logic [39:0] o_cmd_response;
  logic [3:0]  o_dat_status;

  int n_checks = 0;
  int n_fail   = 0;
  logic stream[$];
  logic dq[$];

  sd_cmd_resp_unit #(.NCR_MAX(NCR), .DLY_W(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_do(i_do), .i_cmd_start(i_cmd_start),
    .i_cmd_index(i_cmd_index), .i_cmd_arg(i_cmd_arg), .i_cmd_long(i_cmd_long),
    .o_cmd_di(o_cmd_di), .o_cmd_busy(o_cmd_busy), .o_cmd_finish(o_cmd_finish),
    .o_cmd_rp_finish(o_cmd_rp_finish), .o_cmd_response(o_cmd_response),
    .i_dat_clear(i_dat_clear), .o_dat_finish(o_dat_finish), .o_dat_status(o_dat_status),
    .i_dly_start(i_dly_start), .i_dly_times(i_dly_times), .o_dly_finish(o_dly_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Card MISO driver: one queued bit per clock, changed well after the rising edge.
  initial begin
    i_do = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      i_do = (dq.size() > 0) ? dq.pop_front() : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic sget(input int j);
    return (j < stream.size()) ? stream[j] : 1'b1;
  endfunction

  function automatic int first_bit(input logic v, input int from, input int lim);
    for (int j = from; j < lim; j++) if (sget(j) == v) return j;
    return -1;
  endfunction

  task automatic push_ones(input int n);
    repeat (n) stream.push_back(1'b1);
  endtask

  task automatic push_bits(input logic [39:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stream.push_back(v[k]);
  endtask

  // Sends one command, plays `stream` on MISO after the frame, checks everything against the model.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic lng, output logic [47:0] frame, output logic [3:0] st);
    int len, lead, exp_rp, z, b, exp_dat, ncyc, rp_seen, rp_cnt, dat_seen;
    logic [39:0] exp_rsp;
    logic [3:0]  exp_st;
    len  = lng ? R7_LEN : R1_LEN;
    lead = first_bit(1'b0, 0, NCR);
    exp_rsp = '0;
    if (lead < 0) begin
      exp_rp  = NCR;
      exp_rsp = '1;
    end else begin
      exp_rp = lead + len;
      for (int k = 0; k < len; k++) exp_rsp = {exp_rsp[38:0], sget(lead + k)};
    end
    z = first_bit(1'b0, exp_rp + 1, stream.size() + 1);
    exp_st  = '0;
    exp_dat = -1;
    if (z >= 0) begin
      for (int k = 1; k <= 4; k++) exp_st = {exp_st[2:0], sget(z + k)};
      b = first_bit(1'b1, z + 5, z + 7 + stream.size());
      exp_dat = b + 1;
    end

    i_cmd_start = 1'b0;
    i_dat_clear = 1'b1;
    step();
    i_dat_clear = 1'b0;
    i_cmd_index = idx;
    i_cmd_arg   = arg;
    i_cmd_long  = lng;
    i_cmd_start = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      frame[47 - i] = o_cmd_di;
      if (i == 0) check_val($sformatf("%s_busy_first_bit", tag), o_cmd_busy, 1);
    end
    check_val($sformatf("%s_frame", tag), frame,
              {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1});
    step();
    dq = stream;
    rp_seen  = -1;
    rp_cnt   = 0;
    dat_seen = -1;
    ncyc = ((stream.size() > NCR) ? stream.size() : NCR) + 20;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (o_cmd_rp_finish) begin
        rp_cnt++;
        if (rp_seen < 0) rp_seen = c;
      end
      if (o_dat_finish && dat_seen < 0) dat_seen = c;
    end
    check_val($sformatf("%s_rp_cycle", tag), rp_seen, exp_rp);
    check_val($sformatf("%s_rp_pulses", tag), rp_cnt, 1);
    check_val($sformatf("%s_response", tag), o_cmd_response, exp_rsp);
    check_val($sformatf("%s_finish_held", tag), o_cmd_finish, 1);
    check_val($sformatf("%s_busy_held", tag), o_cmd_busy, 1);
    check_val($sformatf("%s_no_restart", tag), o_cmd_di, 1);
    check_val($sformatf("%s_dat_cycle", tag), dat_seen, exp_dat);
    check_val($sformatf("%s_dat_status", tag), o_dat_status, exp_st);
    st = o_dat_status;
    i_cmd_start = 1'b0;
    step();
    check_val($sformatf("%s_busy_release", tag), o_cmd_busy, 0);
    check_val($sformatf("%s_finish_release", tag), o_cmd_finish, 0);
  endtask

  task automatic dly_test(input int n, input int hold);
    int seen;
    seen = -1;
    i_dly_times = n[3:0];
    i_dly_start = 1'b1;
    for (int e = 1; e <= n + hold; e++) begin
      step();
      if (o_dly_finish && seen < 0) seen = e;
    end
    check_val($sformatf("dly%0d_rise_edge", n), seen, n + 1);
    check_val($sformatf("dly%0d_hold", n), o_dly_finish, 1);
    i_dly_start = 1'b0;
    step();
    check_val($sformatf("dly%0d_drop", n), o_dly_finish, 0);
  endtask

  initial begin
    logic [47:0] frame;
    logic [3:0]  st;
    int busy_cnt, rp_cnt, lead, gap;
    logic lng;
    i_reset = 1'b1;
    i_cmd_start = 1'b0; i_cmd_long = 1'b0; i_cmd_index = '0; i_cmd_arg = '0;
    i_dat_clear = 1'b0; i_dly_start = 1'b0; i_dly_times = '0;
    repeat (2) step();
    check_val("rst_cmd_di", o_cmd_di, 1);
    check_val("rst_busy", o_cmd_busy, 0);
    check_val("rst_finish", o_cmd_finish, 0);
    check_val("rst_rp_finish", o_cmd_rp_finish, 0);
    check_val("rst_response", o_cmd_response, 0);
    check_val("rst_dat_finish", o_dat_finish, 0);
    check_val("rst_dat_status", o_dat_status, 0);
    check_val("rst_dly_finish", o_dly_finish, 0);
    i_reset = 1'b0;
    step();

    stream.delete(); push_ones(2); push_bits(40'h01, 8);
    run_cmd("cmd0", 6'd0, 32'd0, 1'b0, frame, st);
    check_val("cmd0_frame_const", frame, 48'h40_0000_0000_95);

    stream.delete(); push_ones(4); push_bits(40'h01_0000_01AA, 40);
    run_cmd("cmd8", 6'd8, 32'h1AA, 1'b1, frame, st);
    check_val("cmd8_crc_byte", frame[7:0], 8'h87);

    stream.delete();
    run_cmd("cmd24_timeout", 6'd24, $urandom, 1'b0, frame, st);

    stream.delete(); push_ones(1); push_bits(40'h00, 8); push_bits(40'hFFFF, 16);
    push_bits(40'hE5, 8); push_bits(40'h0, 3); push_ones(2);
    run_cmd("cmd24_write", 6'd24, 32'h200, 1'b0, frame, st);
    check_val("cmd24_token_accepted", st, TOK_ACCEPTED);
    i_dat_clear = 1'b1;
    step();
    i_dat_clear = 1'b0;
    check_val("dat_clear_finish", o_dat_finish, 0);
    check_val("dat_clear_status", o_dat_status, 0);

    for (int t = 0; t < 8; t++) begin
      lng  = 1'($urandom_range(0, 1));
      lead = ($urandom_range(0, 7) == 0) ? NCR + 5 : int'($urandom_range(0, 12));
      stream.delete();
      push_ones(lead);
      push_bits({1'b0, 39'({$urandom, $urandom})}, lng ? 40 : 8);
      if ($urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, 12);
        push_ones(gap);
        push_bits(40'h0, 1);
        push_bits(40'($urandom_range(0, 15)), 4);
        push_bits(40'h0, $urandom_range(0, 6));
      end
      run_cmd($sformatf("rand%0d", t), 6'($urandom), $urandom, lng, frame, st);
    end

    // Reset landing in the middle of a frame.
    stream.delete();
    i_cmd_index = 6'd17; i_cmd_arg = $urandom; i_cmd_long = 1'b0; i_cmd_start = 1'b1;
    repeat (21) step();
    #2;
    i_reset = 1'b1;
    #1;
    check_val("midrst_cmd_di", o_cmd_di, 1);
    check_val("midrst_busy", o_cmd_busy, 0);
    step();
    i_reset = 1'b0;
    for (int k = 0; k < 8; k++) dq.push_back(1'b0);
    busy_cnt = 0;
    rp_cnt   = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (o_cmd_busy) busy_cnt++;
      if (o_cmd_rp_finish) rp_cnt++;
    end
    check_val("midrst_no_restart", busy_cnt, 0);
    check_val("midrst_no_rp", rp_cnt, 0);
    check_val("midrst_response", o_cmd_response, 0);
    i_cmd_start = 1'b0;
    step();
    i_cmd_start = 1'b1;
    step();
    check_val("midrst_fresh_start", o_cmd_busy, 1);
    i_reset = 1'b1;
    step();
    i_cmd_start = 1'b0;
    i_reset = 1'b0;
    step();

    dly_test(3, 4);
    dly_test(0, 3);
    dly_test(15, 30);
    for (int t = 0; t < 2; t++) dly_test(int'($urandom_range(0, 15)), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
